// File: rtl/audioport_pkg.sv
// rtl/audioport_pkg.sv - shared constants and types for the audio port receive path
//
// Purpose : word length, bit-counter sizing and the I2S receiver state type.
// Ports   : none (package).

package audioport_pkg;

  localparam int I2S_WORD_BITS = 24;
  localparam int I2S_CNT_BITS  = 5;

  // Bit counter value meaning "more than a full word seen in this ws phase".
  localparam logic [I2S_CNT_BITS-1:0] I2S_CNT_SAT = I2S_CNT_BITS'(I2S_WORD_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    RX_CH0 = 2'd2,
    RX_CH1 = 2'd3
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// rtl/i2s_rx_sync.sv - pin synchronisers and sck rising-edge detector for the I2S receiver
//
// Purpose : brings sck/ws/sdi into the clk domain through two flops each and
//           flags the cycle in which the synchronised sck goes 0 -> 1.
// Ports   : clk, rst_n        - system clock, synchronous active-low reset
//           sck_in, ws_in,
//           sdi_in            - asynchronous I2S pins
//           sck_rise          - one-clk strobe, synchronised sck rose
//           ws_sync, sdi_sync - synchronised ws/sdi, valid to sample on sck_rise

module i2s_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_in,
  input  logic ws_in,
  input  logic sdi_in,
  output logic sck_rise,
  output logic ws_sync,
  output logic sdi_sync
);

  logic [1:0] sck_ff;
  logic [1:0] ws_ff;
  logic [1:0] sdi_ff;
  logic       sck_prev;

  // All three pins see identical latency, so ws/sdi stay aligned with the
  // sck edge they were launched against.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_ff   <= 2'b00;
      ws_ff    <= 2'b00;
      sdi_ff   <= 2'b00;
      sck_prev <= 1'b0;
    end else begin
      sck_ff   <= {sck_ff[0], sck_in};
      ws_ff    <= {ws_ff[0], ws_in};
      sdi_ff   <= {sdi_ff[0], sdi_in};
      sck_prev <= sck_ff[1];
    end
  end

  assign sck_rise = sck_ff[1] & ~sck_prev;
  assign ws_sync  = ws_ff[1];
  assign sdi_sync = sdi_ff[1];

endmodule

// File: rtl/i2s_rx_unit.sv
// rtl/i2s_rx_unit.sv - left-justified 24-bit stereo I2S receiver
//
// Purpose : deserialises a two-channel left-justified I2S stream (ws change
//           marks the MSB of the next channel) and presents complete stereo
//           pairs with a valid strobe; flags words that are not exactly 24 bits.
// Ports   : clk, rst_n        - system clock, synchronous active-low reset
//           rx_en_in          - 1 = receive, 0 = standby (partial word dropped)
//           sck_in, ws_in,
//           sdi_in            - asynchronous I2S pins
//           audio0_out        - last complete channel-0 (left) sample
//           audio1_out        - last complete channel-1 (right) sample
//           valid_out         - one-clk pulse, new pair on audio0/1_out
//           frame_err_out     - one-clk pulse, word length error

module i2s_rx_unit
  import audioport_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_en_in,
  input  logic                     sck_in,
  input  logic                     ws_in,
  input  logic                     sdi_in,
  output logic [I2S_WORD_BITS-1:0] audio0_out,
  output logic [I2S_WORD_BITS-1:0] audio1_out,
  output logic                     valid_out,
  output logic                     frame_err_out
);

  localparam logic [I2S_CNT_BITS-1:0] WORD_CNT = I2S_CNT_BITS'(I2S_WORD_BITS);
  localparam logic [I2S_CNT_BITS-1:0] LAST_CNT = I2S_CNT_BITS'(I2S_WORD_BITS - 1);

  logic sck_rise;
  logic ws_sync;
  logic sdi_sync;

  i2s_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck_in   (sck_in),
    .ws_in    (ws_in),
    .sdi_in   (sdi_in),
    .sck_rise (sck_rise),
    .ws_sync  (ws_sync),
    .sdi_sync (sdi_sync)
  );

  i2s_rx_state_t state, state_d;

  logic                     ws_prev;
  logic [I2S_WORD_BITS-1:0] shift_q;
  logic [I2S_CNT_BITS-1:0]  cnt_q;
  logic [I2S_WORD_BITS-1:0] ch0_q;
  logic [I2S_WORD_BITS-1:0] audio0_q;
  logic [I2S_WORD_BITS-1:0] audio1_q;
  logic                     valid_q;
  logic                     err_q;

  // Datapath commands decoded by the next-state logic.
  logic start_word;
  logic shift_bit;
  logic cnt_sat;
  logic clear_word;
  logic hold_ch0;
  logic deliver;
  logic err;

  logic ws_edge;
  assign ws_edge = sck_rise & (ws_sync != ws_prev);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    start_word = 1'b0;
    shift_bit  = 1'b0;
    cnt_sat    = 1'b0;
    clear_word = 1'b0;
    hold_ch0   = 1'b0;
    deliver    = 1'b0;
    err        = 1'b0;

    if (!rx_en_in) begin
      state_d    = IDLE;
      clear_word = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_d = SYNC;
        end

        SYNC: begin
          // Only a 1 -> 0 ws transition gives a trustworthy channel-0 MSB.
          if (sck_rise && !ws_sync && ws_prev) begin
            state_d    = RX_CH0;
            start_word = 1'b1;
          end
        end

        RX_CH0, RX_CH1: begin
          if (ws_edge) begin
            if (cnt_q == WORD_CNT) begin
              // The bit on this edge is already the next channel's MSB.
              start_word = 1'b1;
              hold_ch0   = (state == RX_CH0);
              state_d    = (state == RX_CH0) ? RX_CH1 : RX_CH0;
            end else begin
              err        = 1'b1;
              clear_word = 1'b1;
              state_d    = SYNC;
            end
          end else if (sck_rise) begin
            if (cnt_q < WORD_CNT) begin
              shift_bit = 1'b1;
              // Pair is published on the last ch1 bit, not on the ws change,
              // so a trailing overlong ch1 phase cannot retract it.
              deliver   = (state == RX_CH1) && (cnt_q == LAST_CNT);
            end else begin
              cnt_sat = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws_prev  <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      ch0_q    <= '0;
      audio0_q <= '0;
      audio1_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (sck_rise) begin
        ws_prev <= ws_sync;
      end

      valid_q <= deliver;
      err_q   <= err;

      if (clear_word) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (start_word) begin
        shift_q <= {{(I2S_WORD_BITS-1){1'b0}}, sdi_sync};
        cnt_q   <= I2S_CNT_BITS'(1);
      end else if (shift_bit) begin
        shift_q <= {shift_q[I2S_WORD_BITS-2:0], sdi_sync};
        cnt_q   <= cnt_q + I2S_CNT_BITS'(1);
      end else if (cnt_sat) begin
        cnt_q   <= I2S_CNT_SAT;
      end

      if (hold_ch0) begin
        ch0_q <= shift_q;
      end

      if (deliver) begin
        audio0_q <= ch0_q;
        audio1_q <= {shift_q[I2S_WORD_BITS-2:0], sdi_sync};
      end
    end
  end

  assign audio0_out    = audio0_q;
  assign audio1_out    = audio1_q;
  assign valid_out     = valid_q;
  assign frame_err_out = err_q;

endmodule

// File: tb/tb_i2s_rx_unit.sv
// tb/tb_i2s_rx_unit.sv - directed scoreboard bench for i2s_rx_unit

module tb_i2s_rx_unit;
  import audioport_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_en_in;
  logic        sck_in;
  logic        ws_in;
  logic        sdi_in;
  logic [23:0] audio0_out;
  logic [23:0] audio1_out;
  logic        valid_out;
  logic        frame_err_out;

  i2s_rx_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_en_in      (rx_en_in),
    .sck_in        (sck_in),
    .ws_in         (ws_in),
    .sdi_in        (sdi_in),
    .audio0_out    (audio0_out),
    .audio1_out    (audio1_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out)
  );

  always #5 clk = ~clk;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  int valid_cnt = 0;
  int err_cnt   = 0;
  int n_tests   = 0;
  int n_fail    = 0;

  always @(negedge clk) begin
    if (valid_out) begin
      obs_q.push_back({audio0_out, audio1_out});
      valid_cnt++;
    end
    if (frame_err_out) err_cnt++;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic w, input logic d, input int h);
    sck_in = 1'b0;
    ws_in  = w;
    sdi_in = d;
    tick(h);
    sck_in = 1'b1;
    tick(h);
  endtask

  task automatic send_word(input logic w, input logic [31:0] data, input int n, input int h);
    for (int i = n - 1; i >= 0; i--) send_bit(w, data[i], h);
  endtask

  task automatic drain(input string tag);
    logic [47:0] e;
    logic [47:0] o;
    chk({tag, "_count"}, 48'(obs_q.size()), 48'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_pair"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  int v0, e0;

  initial begin
    rst_n = 1'b0; rx_en_in = 1'b0; sck_in = 1'b0; ws_in = 1'b0; sdi_in = 1'b0;
    tick(3);
    chk("rst_audio0", 48'(audio0_out), 48'h0);
    chk("rst_audio1", 48'(audio1_out), 48'h0);
    chk("rst_valid", 48'(valid_out), 48'h0);
    chk("rst_err", 48'(frame_err_out), 48'h0);
    chk("rst_state", 48'(dut.state), 48'(IDLE));
    rst_n = 1'b1;
    tick(2);

    // Nominal frame, sck 4/4.
    v0 = valid_cnt; e0 = err_cnt;
    rx_en_in = 1'b1;
    tick(2);
    send_word(1'b0, 32'h0, 24, 4);
    send_word(1'b1, 32'h0, 24, 4);
    exp_q.push_back({24'hA5F00F, 24'h123456});
    send_word(1'b0, 32'h00A5F00F, 24, 4);
    send_word(1'b1, 32'h00123456, 24, 4);
    tick(10);
    drain("nominal");
    chk("nominal_err", 48'(err_cnt - e0), 48'h0);
    chk("nominal_out1", 48'(audio1_out), 48'h123456);

    // Fast sck 2/2, eight back-to-back frames.
    v0 = valid_cnt; e0 = err_cnt;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({24'h000100 + 24'(k), 24'hF00000 + 24'(k)});
      send_word(1'b0, 32'h00000100 + 32'(k), 24, 2);
      send_word(1'b1, 32'h00F00000 + 32'(k), 24, 2);
    end
    tick(10);
    drain("fast");
    chk("fast_valid_n", 48'(valid_cnt - v0), 48'd8);
    chk("fast_err", 48'(err_cnt - e0), 48'h0);

    // Short channel-1 word, then resync and one good frame.
    v0 = valid_cnt; e0 = err_cnt;
    send_word(1'b0, 32'h00111111, 24, 2);
    send_word(1'b1, 32'h00222222, 23, 2);
    send_word(1'b0, 32'h0, 24, 2);
    tick(6);
    chk("short_err", 48'(err_cnt - e0), 48'd1);
    chk("short_valid", 48'(valid_cnt - v0), 48'd0);
    send_word(1'b1, 32'h0, 24, 2);
    exp_q.push_back({24'h0C0FFE, 24'hBEEF01});
    send_word(1'b0, 32'h000C0FFE, 24, 2);
    send_word(1'b1, 32'h00BEEF01, 24, 2);
    tick(10);
    drain("resync");
    chk("resync_err", 48'(err_cnt - e0), 48'd1);

    // Long channel-0 word (26 bits).
    v0 = valid_cnt; e0 = err_cnt;
    send_word(1'b0, 32'h03FFFFFF, 26, 2);
    send_bit(1'b1, 1'b0, 2);
    tick(6);
    chk("long_err", 48'(err_cnt - e0), 48'd1);
    chk("long_valid", 48'(valid_cnt - v0), 48'd0);
    chk("long_state", 48'(dut.state), 48'(SYNC));

    // Disable after 10 channel-0 bits.
    v0 = valid_cnt; e0 = err_cnt;
    send_word(1'b0, 32'h000003FF, 10, 2);
    tick(4);
    chk("dis_state_pre", 48'(dut.state), 48'(RX_CH0));
    rx_en_in = 1'b0;
    tick(1);
    chk("dis_state", 48'(dut.state), 48'(IDLE));
    tick(5);
    chk("dis_audio0", 48'(audio0_out), 48'h0C0FFE);
    chk("dis_audio1", 48'(audio1_out), 48'hBEEF01);
    chk("dis_pulses", 48'((valid_cnt - v0) + (err_cnt - e0)), 48'd0);

    // Reset during channel 1, then recover.
    rx_en_in = 1'b1;
    tick(2);
    v0 = valid_cnt; e0 = err_cnt;
    send_word(1'b1, 32'h0, 24, 2);
    send_word(1'b0, 32'h00777777, 24, 2);
    send_word(1'b1, 32'h00888888, 10, 2);
    rst_n = 1'b0;
    tick(1);
    chk("mrst_audio0", 48'(audio0_out), 48'h0);
    chk("mrst_state", 48'(dut.state), 48'(IDLE));
    tick(1);
    rst_n = 1'b1;
    rx_en_in = 1'b0;
    tick(2);
    chk("mrst_audio1", 48'(audio1_out), 48'h0);
    chk("mrst_pulses", 48'((valid_cnt - v0) + (err_cnt - e0)), 48'd0);
    rx_en_in = 1'b1;
    tick(2);
    send_word(1'b1, 32'h0, 24, 2);
    exp_q.push_back({24'h5A5A5A, 24'h00FF00});
    send_word(1'b0, 32'h005A5A5A, 24, 2);
    send_word(1'b1, 32'h0000FF00, 24, 2);
    tick(10);
    drain("post_rst");
    chk("post_rst_err", 48'(err_cnt - e0), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx_unit.md
I2S_RX_UNIT -- requirements
Module: i2s_rx_unit

Interface
REQ-001 The block SHALL have clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-002 The block SHALL have rst_n, input, 1, a synchronous active-low reset sampled on rising clk.
REQ-003 The block SHALL have rx_en_in, input, 1; 1 = receive enabled, 0 = standby.
REQ-004 The block SHALL have sck_in, input, 1, the external I2S serial clock, asynchronous to clk.
REQ-005 The block SHALL have ws_in, input, 1, the external word select (0 = channel 0 / left, 1 = channel 1 / right), asynchronous.
REQ-006 The block SHALL have sdi_in, input, 1, the external serial data, MSB first, asynchronous.
REQ-007 The block SHALL have audio0_out, output, 24, the last complete channel-0 sample.
REQ-008 The block SHALL have audio1_out, output, 24, the last complete channel-1 sample.
REQ-009 The block SHALL have valid_out, output, 1, a one-clk pulse when a new stereo pair is on audio0_out/audio1_out.
REQ-010 The block SHALL have frame_err_out, output, 1, a one-clk pulse on a framing error.

Function
REQ-011 sck_in, ws_in and sdi_in SHALL each pass through a 2-flop synchroniser before any use.
REQ-012 A sck rising edge SHALL be detected when the synchronised sck is 1 and its previous-cycle value is 0.
REQ-013 ws and sdi SHALL be sampled in the clk cycle the sck rise is detected (3 clk after the pin edge).
REQ-014 The block SHALL support sck high and low phases of at least 2 clk each (the transmitter produces 2/2 and 4/4).
REQ-015 The FSM states SHALL be IDLE, SYNC, RX_CH0 and RX_CH1.
REQ-016 IDLE SHALL be entered when rx_en_in = 0, from any state, in the next cycle, and any partial word SHALL be discarded.
REQ-017 IDLE -> SYNC SHALL occur when rx_en_in = 1.
REQ-018 SYNC -> RX_CH0 SHALL occur on the first sck rise whose sampled ws is 0 and whose previous sampled ws was 1; that bit is bit 23 of channel 0.
REQ-019 In RX_CHn, each sck rise SHALL shift sdi into a 24-bit shift register LSB-side and increment a 5-bit bit counter.
REQ-020 A sampled ws change SHALL mark the first bit of the next channel (left-justified, no one-bit delay, matching the transmitter).
REQ-021 RX_CH0 SHALL go to RX_CH1 on the sck rise where ws samples 1, provided the bit count is 24; the channel-0 word SHALL be held in an internal register.
REQ-022 RX_CH1 SHALL go to RX_CH0 on the sck rise where ws samples 0, provided the bit count is 24.
REQ-023 When the 24th channel-1 bit is sampled, audio0_out and audio1_out SHALL update and valid_out SHALL pulse in the next clk cycle.
REQ-024 Bits beyond 24 within one ws phase SHALL be ignored, and the counter SHALL saturate at 25.
REQ-025 On a ws change with bit count ≠ 24 in RX_CH0 or RX_CH1, frame_err_out SHALL pulse, the word SHALL be discarded, and the FSM SHALL enter SYNC.
REQ-026 In SYNC, no errors and no valid_out SHALL be produced.
REQ-027 audio0_out and audio1_out SHALL hold their values between valid_out pulses.
REQ-028 audio0_out and audio1_out SHALL NOT be cleared when rx_en_in falls.

Reset
REQ-029 While rst_n = 0, the FSM SHALL be in IDLE, and all synchronisers, counters, shift and holding registers SHALL be 0.
REQ-030 While rst_n = 0, audio0_out and audio1_out SHALL be 24'h0, and valid_out and frame_err_out SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort reception without producing valid_out or frame_err_out.

Structure
REQ-032 The word length constant I2S_WORD_BITS = 24 and the state enum type i2s_rx_state_t SHALL live in audioport_pkg.
REQ-033 The synchroniser plus sck edge detector SHALL be a sub-module, i2s_rx_sync.
REQ-034 All other logic SHALL stay in i2s_rx_unit.

Verification
REQ-035 The bench SHALL cover a nominal frame: enable, sck 4/4 clk, one sync frame, then ch0 = 24'hA5F00F, ch1 = 24'h123456 -> a valid_out pulse with those values, and frame_err_out stays 0.
REQ-036 The bench SHALL cover a fast sck: 2/2 clk, 8 consecutive frames with incrementing data -> 8 valid_out pulses with correct data.
REQ-037 The bench SHALL cover a short word: ws toggles after 23 ch1 bits -> one frame_err_out pulse, no valid_out; the next complete frame after resync is received correctly.
REQ-038 The bench SHALL cover a long word: 26 bits in a ch0 phase -> frame_err_out pulse, FSM in SYNC.
REQ-039 The bench SHALL cover disable mid-frame: rx_en_in = 0 after 10 ch0 bits -> IDLE next cycle, outputs keep the previous pair, no pulses.
REQ-040 The bench SHALL cover reset mid-frame: rst_n = 0 for 2 clk during ch1 -> outputs 0, no pulses; after release and re-enable, the first full frame is delivered.
